fft_agu_param: RTL and testbench
================================

FFT_AGU_PARAM -- requirements
Module: fft_agu_param

Interface
REQ-001 SHALL have parameter LOG2N, default 5, meaning log2 of FFT points N; legal range 2..10.
REQ-002 SHALL have parameter STAGE_GAP, default 2, meaning bubble cycles inserted between stages for memory read-to-write drain; legal range 0..15.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port clr  input  1  asynchronous active-high reset.
REQ-005 SHALL have port start_fft  input  1  single-cycle request to begin a transform.
REQ-006 SHALL have port hold  input  1  stall; freezes counters, FSM and output pipeline.
REQ-007 SHALL have port mema_address  output  LOG2N  butterfly upper-leg address.
REQ-008 SHALL have port memb_address  output  LOG2N  butterfly lower-leg address.
REQ-009 SHALL have port twiddle_address  output  LOG2N-1  twiddle ROM index.
REQ-010 SHALL have port mem_write  output  1  addresses valid, write strobe.
REQ-011 SHALL have port bank_sel  output  1  ping-pong memory bank of current stage's reads.
REQ-012 SHALL have port busy  output  1  high from accepted start until fft_done.
REQ-013 SHALL have port fft_done  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL contain butterfly index j (LOG2N-1 bits, 0..N/2-1) and stage counter s (0..LOG2N-1).
REQ-015 SHALL implement FSM IDLE -> RUN -> GAP -> RUN ... -> FLUSH -> DONE -> IDLE.
REQ-016 IDLE: start_fft=1 SHALL move to RUN next cycle with j=0, s=0; start_fft outside IDLE SHALL be ignored.
REQ-017 RUN: j SHALL increment each unstalled cycle; at j=N/2-1 with s<LOG2N-1, go to GAP (or directly RUN with s+1 if STAGE_GAP=0); with s=LOG2N-1, go to FLUSH.
REQ-018 GAP: SHALL last STAGE_GAP unstalled cycles, then RUN with j=0, s incremented.
REQ-019 mema_address SHALL equal (2j) rotated left by s within LOG2N bits.
REQ-020 memb_address SHALL equal (2j+1) rotated left by s within LOG2N bits.
REQ-021 twiddle_address SHALL equal (j >> (LOG2N-1-s)) << (LOG2N-1-s), truncated to LOG2N-1 bits.
REQ-022 Address, twiddle and mem_write outputs SHALL be registered with fixed latency 2 cycles from the counter state that generated them.
REQ-023 mem_write SHALL be 1 only for outputs generated in RUN; 0 for GAP, FLUSH, IDLE, DONE.
REQ-024 bank_sel SHALL equal s[0] delayed by the same 2-cycle latency, so it toggles per stage.
REQ-025 FLUSH SHALL last 2 cycles to drain the pipeline; DONE SHALL last 1 cycle asserting fft_done.
REQ-026 hold=1 SHALL freeze j, s, FSM and all pipeline registers; outputs keep their values; a hold in DONE SHALL extend the fft_done pulse.
REQ-027 busy SHALL be 1 in RUN, GAP, FLUSH, DONE; 0 in IDLE.
REQ-028 start_fft arriving in the DONE cycle SHALL be ignored; back-to-back transforms need start_fft in IDLE.

Reset
REQ-029 clr=1 SHALL immediately force IDLE, j=0, s=0, pipeline cleared: all addresses 0, twiddle 0, mem_write 0, bank_sel 0, busy 0, fft_done 0.
REQ-030 clr mid-transform SHALL abort with no further mem_write and no fft_done.

Configuration
REQ-031 Macro FFT_AGU_BITREV_EN, when defined, SHALL add output unload_valid (1 bit) and an UNLOAD state between FLUSH and DONE lasting N cycles, with mema_address = sequential k=0..N-1 and memb_address = bit-reverse(k), same 2-cycle latency, mem_write=0, bank_sel = LOG2N[0]; one extra FLUSH of 2 cycles precedes DONE.
REQ-032 Without FFT_AGU_BITREV_EN, UNLOAD and unload_valid SHALL not exist; FLUSH goes directly to DONE.

Verification
REQ-033 LOG2N=3, STAGE_GAP=2, start_fft at cycle 0 -> mem_write high cycles 3-6, 9-12, 15-18; fft_done pulse at cycle 21; busy 1-21.
REQ-034 LOG2N=3, stage 1, j=2 -> mema=1, memb=3, twiddle=2, bank_sel=1; stage 2, j=1 -> mema=1, memb=5, twiddle=1, bank_sel=0.
REQ-035 hold=1 for 3 cycles during stage 1 -> address sequence unchanged, fft_done delayed by exactly 3 cycles.
REQ-036 clr pulsed mid-stage 1 -> next cycle all outputs 0, busy 0, no fft_done; new start_fft runs a full clean transform.
REQ-037 start_fft held high throughout -> second transform starts only after return to IDLE, no overlap.
REQ-038 FFT_AGU_BITREV_EN, LOG2N=3 -> unload_valid for 8 cycles, memb_address sequence 0,4,2,6,1,5,3,7.

Source files
------------

// File: rtl/fft_agu_param.sv
// Radix-2 in-place FFT address generator with a 2-cycle registered output pipeline.
// Define FFT_AGU_BITREV_EN to add a bit-reversed unload phase and the unload_valid output.
module fft_agu_param #(
  parameter int LOG2N     = 5,
  parameter int STAGE_GAP = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start_fft,
  input  logic             hold,
  output logic [LOG2N-1:0] mema_address,
  output logic [LOG2N-1:0] memb_address,
  output logic [LOG2N-2:0] twiddle_address,
  output logic             mem_write,
  output logic             bank_sel,
  output logic             busy,
`ifdef FFT_AGU_BITREV_EN
  output logic             unload_valid,
`endif
  output logic             fft_done
);

  localparam int JW = LOG2N - 1;
  localparam logic [JW-1:0] J_LAST     = '1;
  localparam logic [3:0]    S_LAST     = 4'(LOG2N - 1);
  localparam logic [3:0]    GAP_LAST   = 4'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);
  // Last writes are still in the output pipeline for 2 cycles, then 2 drain cycles follow.
  localparam logic [3:0]    FLUSH_LAST = 4'd3;
`ifdef FFT_AGU_BITREV_EN
  localparam logic [3:0]       FLUSH2_LAST = 4'd1;
  localparam logic [LOG2N-1:0] K_LAST      = '1;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_GAP, S_FLUSH,
`ifdef FFT_AGU_BITREV_EN
    S_UNLOAD, S_FLUSH2,
`endif
    S_DONE
  } state_t;

  typedef struct packed {
    logic [LOG2N-1:0] a;
    logic [LOG2N-1:0] b;
    logic [JW-1:0]    tw;
    logic             wr;
    logic             bank;
`ifdef FFT_AGU_BITREV_EN
    logic             uv;
`endif
  } pipe_t;

  function automatic logic [LOG2N-1:0] rotl(input logic [LOG2N-1:0] x, input logic [3:0] sh);
    logic [2*LOG2N-1:0] dbl;
    dbl = {x, x} << sh;
    return dbl[2*LOG2N-1:LOG2N];
  endfunction

`ifdef FFT_AGU_BITREV_EN
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
    return r;
  endfunction
  logic [LOG2N-1:0] k_q, k_d;
`endif

  state_t        state_q, state_d;
  logic [JW-1:0] j_q, j_d;
  logic [3:0]    s_q, s_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    tw_sh;
  logic          busy_q, done_q;
  pipe_t         p0, p1_q, p2_q;

  assign tw_sh = S_LAST - s_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    j_d     = j_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
`ifdef FFT_AGU_BITREV_EN
    k_d     = k_q;
`endif
    case (state_q)
      S_IDLE: if (start_fft) begin
        state_d = S_RUN;
        j_d     = '0;
        s_d     = '0;
      end
      S_RUN: begin
        j_d = j_q + JW'(1);
        if (j_q == J_LAST) begin
          cnt_d = '0;
          if (s_q == S_LAST)      state_d = S_FLUSH;
          else if (STAGE_GAP == 0) s_d    = s_q + 4'd1;
          else                     state_d = S_GAP;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == GAP_LAST) begin
          state_d = S_RUN;
          j_d     = '0;
          s_d     = s_q + 4'd1;
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == FLUSH_LAST) begin
`ifdef FFT_AGU_BITREV_EN
          state_d = S_UNLOAD;
          k_d     = '0;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef FFT_AGU_BITREV_EN
      S_UNLOAD: begin
        k_d = k_q + LOG2N'(1);
        if (k_q == K_LAST) begin
          state_d = S_FLUSH2;
          cnt_d   = '0;
        end
      end
      S_FLUSH2: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == FLUSH2_LAST) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
        j_d     = '0;
        s_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output-pipeline entry: addresses are only meaningful in RUN (and UNLOAD), zero elsewhere.
  always_comb begin
    p0      = '0;
    p0.bank = s_q[0];
    case (state_q)
      S_RUN: begin
        p0.a  = rotl({j_q, 1'b0}, s_q);
        p0.b  = rotl({j_q, 1'b1}, s_q);
        p0.tw = (j_q >> tw_sh) << tw_sh;
        p0.wr = 1'b1;
      end
`ifdef FFT_AGU_BITREV_EN
      S_UNLOAD: begin
        p0.a    = k_q;
        p0.b    = bitrev(k_q);
        p0.bank = 1'(LOG2N % 2);
        p0.uv   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // NOTE: state and pipeline flops use non-blocking assignments; the pipeline is plain flops, so it is reset.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      j_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p1_q    <= '0;
      p2_q    <= '0;
`ifdef FFT_AGU_BITREV_EN
      k_q     <= '0;
`endif
    end else if (!hold) begin
      state_q <= state_d;
      j_q     <= j_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      p1_q    <= p0;
      p2_q    <= p1_q;
`ifdef FFT_AGU_BITREV_EN
      k_q     <= k_d;
`endif
    end
  end

  assign mema_address    = p2_q.a;
  assign memb_address    = p2_q.b;
  assign twiddle_address = p2_q.tw;
  assign mem_write       = p2_q.wr;
  assign bank_sel        = p2_q.bank;
  assign busy            = busy_q;
  assign fft_done        = done_q;
`ifdef FFT_AGU_BITREV_EN
  assign unload_valid    = p2_q.uv;
`endif

endmodule

// File: tb/tb_fft_agu_param.sv
// Self-checking bench for fft_agu_param (LOG2N=3, STAGE_GAP=2): directed tables, corner sequences
// and randomized start/hold/clr traffic against a schedule-based reference model.
module tb_fft_agu_param;
  localparam int L = 3;
  localparam int G = 2;
  localparam int N = 1 << L;
  localparam int H = N / 2;
`ifdef FFT_AGU_BITREV_EN
  localparam int DONE_CYC = 21 + N + 2;
`else
  localparam int DONE_CYC = 21;
`endif

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         start_fft = 1'b0;
  logic         hold = 1'b0;
  logic [L-1:0] mema_address, memb_address;
  logic [L-2:0] twiddle_address;
  logic         mem_write, bank_sel, busy, fft_done;
`ifdef FFT_AGU_BITREV_EN
  logic         unload_valid;
`endif

  fft_agu_param #(.LOG2N(L), .STAGE_GAP(G)) dut (
    .clk(clk), .clr(clr), .start_fft(start_fft), .hold(hold),
    .mema_address(mema_address), .memb_address(memb_address),
    .twiddle_address(twiddle_address), .mem_write(mem_write),
    .bank_sel(bank_sel), .busy(busy),
`ifdef FFT_AGU_BITREV_EN
    .unload_valid(unload_valid),
`endif
    .fft_done(fft_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a transform is a precomputed list of steps, one per unstalled cycle.
  typedef enum int {K_IDLE, K_RUN, K_GAP, K_FLUSH, K_UNLOAD, K_DONE} kind_t;
  typedef struct {kind_t kind; int j; int s; int k;} step_t;
  typedef struct {int a; int b; int tw; int wr; int bank; int uv;} outs_t;

  step_t sched[$];
  step_t cur;
  outs_t p1, p2;

  function automatic step_t mk(kind_t kd, int j, int s, int k);
    step_t e;
    e.kind = kd; e.j = j; e.s = s; e.k = k;
    return e;
  endfunction

  function automatic int rotl(int v, int r);
    return ((v << r) | (v >> (L - r))) & (N - 1);
  endfunction

  function automatic int bitrev(int v);
    int r = 0;
    for (int i = 0; i < L; i++) if (v & (1 << i)) r |= 1 << (L - 1 - i);
    return r;
  endfunction

  function automatic outs_t f(step_t e);
    outs_t o = '{default: 0};
    o.bank = e.s % 2;
    if (e.kind == K_RUN) begin
      o.a  = rotl(2 * e.j, e.s);
      o.b  = rotl(2 * e.j + 1, e.s);
      o.tw = (e.j >> (L - 1 - e.s)) << (L - 1 - e.s);
      o.wr = 1;
    end else if (e.kind == K_UNLOAD) begin
      o.a    = e.k;
      o.b    = bitrev(e.k);
      o.bank = L % 2;
      o.uv   = 1;
    end
    return o;
  endfunction

  task automatic build();
    sched.delete();
    for (int s = 0; s < L; s++) begin
      for (int j = 0; j < H; j++) sched.push_back(mk(K_RUN, j, s, 0));
      if (s < L - 1) repeat (G) sched.push_back(mk(K_GAP, 0, s, 0));
    end
    repeat (4) sched.push_back(mk(K_FLUSH, 0, L - 1, 0));
`ifdef FFT_AGU_BITREV_EN
    for (int k = 0; k < N; k++) sched.push_back(mk(K_UNLOAD, 0, L - 1, k));
    repeat (2) sched.push_back(mk(K_FLUSH, 0, L - 1, 0));
`endif
    sched.push_back(mk(K_DONE, 0, L - 1, 0));
  endtask

  task automatic model_reset();
    sched.delete();
    cur = mk(K_IDLE, 0, 0, 0);
    p1  = '{default: 0};
    p2  = '{default: 0};
  endtask

  task automatic model_step();
    if (hold) return;
    p2 = p1;
    p1 = f(cur);
    if (cur.kind == K_IDLE) begin
      if (start_fft) begin
        build();
        cur = sched.pop_front();
      end
    end else if (sched.size() > 0) cur = sched.pop_front();
    else cur = mk(K_IDLE, 0, 0, 0);
  endtask

  task automatic compare_model();
    check("mema", mema_address, p2.a);
    check("memb", memb_address, p2.b);
    check("twiddle", twiddle_address, p2.tw);
    check("mem_write", mem_write, p2.wr);
    check("bank_sel", bank_sel, p2.bank);
    check("busy", busy, (cur.kind != K_IDLE) ? 1 : 0);
    check("fft_done", fft_done, (cur.kind == K_DONE) ? 1 : 0);
`ifdef FFT_AGU_BITREV_EN
    check("unload_valid", unload_valid, p2.uv);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic pulse_clr();
    #1 clr = 1'b1;
    model_reset();
    #1;
    check("clr_mema", mema_address, 0);
    check("clr_memb", memb_address, 0);
    check("clr_twiddle", twiddle_address, 0);
    check("clr_mem_write", mem_write, 0);
    check("clr_bank_sel", bank_sel, 0);
    check("clr_busy", busy, 0);
    check("clr_fft_done", fft_done, 0);
    #1 clr = 1'b0;
  endtask

  typedef struct {logic start; logic exp_mw; logic exp_busy; logic exp_done;} vec_t;
  typedef struct {int cyc; int a; int b; int tw; int bank;} av_t;

  vec_t tbl[DONE_CYC + 3];
  av_t  at[4];

  initial begin
    int done_at, done2_at, busy_gap, n_mw, n_done;
    bit held;
    int seq[$];

    for (int c = 0; c < DONE_CYC + 3; c++) begin
      tbl[c].start    = (c == 0);
      tbl[c].exp_mw   = (c >= 3 && c <= 6) || (c >= 9 && c <= 12) || (c >= 15 && c <= 18);
      tbl[c].exp_busy = (c >= 1 && c <= DONE_CYC);
      tbl[c].exp_done = (c == DONE_CYC);
    end
    at[0] = '{6, 6, 7, 0, 0};
    at[1] = '{11, 1, 3, 2, 1};
    at[2] = '{16, 1, 5, 1, 0};
    at[3] = '{18, 3, 7, 3, 0};

    // Reset state
    model_reset();
    #12;
    check("rst_mema", mema_address, 0);
    check("rst_memb", memb_address, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_busy", busy, 0);
    check("rst_fft_done", fft_done, 0);
    clr = 1'b0;
    tick();

    // Reference timeline and addresses of one transform
    for (int c = 0; c < DONE_CYC + 3; c++) begin
      check($sformatf("tbl_mw[%0d]", c), mem_write, tbl[c].exp_mw);
      check($sformatf("tbl_busy[%0d]", c), busy, tbl[c].exp_busy);
      check($sformatf("tbl_done[%0d]", c), fft_done, tbl[c].exp_done);
      for (int i = 0; i < 4; i++) if (at[i].cyc == c) begin
        check($sformatf("tbl_mema[%0d]", c), mema_address, at[i].a);
        check($sformatf("tbl_memb[%0d]", c), memb_address, at[i].b);
        check($sformatf("tbl_tw[%0d]", c), twiddle_address, at[i].tw);
        check($sformatf("tbl_bank[%0d]", c), bank_sel, at[i].bank);
      end
      start_fft = tbl[c].start;
      tick();
    end
    start_fft = 1'b0;

    // Three stalled cycles during stage 1
    done_at = -1; held = 0;
    start_fft = 1'b1; tick(); start_fft = 1'b0;
    for (int c = 1; c < DONE_CYC + 15; c++) begin
      if (fft_done && done_at < 0) done_at = c;
      if (mem_write && !held) seq.push_back(mema_address);
      held = (c >= 8 && c <= 10);
      hold = held;
      tick();
    end
    hold = 1'b0;
    check("hold_done_cycle", done_at, DONE_CYC + 3);
    check("hold_write_count", seq.size(), L * H);
    for (int i = 0; i < seq.size() && i < L * H; i++)
      check($sformatf("hold_seq[%0d]", i), seq[i], rotl(2 * (i % H), i / H));

    // Abort in stage 1, then a clean transform
    start_fft = 1'b1; tick(); start_fft = 1'b0;
    repeat (8) tick();
    pulse_clr();
    n_mw = 0; n_done = 0;
    repeat (DONE_CYC + 5) begin
      tick();
      n_mw += mem_write;
      n_done += fft_done;
    end
    check("abort_mem_write", n_mw, 0);
    check("abort_fft_done", n_done, 0);
    done_at = -1;
    start_fft = 1'b1; tick(); start_fft = 1'b0;
    for (int c = 1; c < DONE_CYC + 10 && done_at < 0; c++) begin
      if (fft_done) done_at = c;
      else tick();
    end
    check("post_clr_done_cycle", done_at, DONE_CYC);
    repeat (3) tick();

    // start_fft held high: second transform begins only after IDLE
    done_at = -1; done2_at = -1; busy_gap = -1;
    start_fft = 1'b1;
    for (int c = 0; c < 2 * DONE_CYC + 6; c++) begin
      if (fft_done && done_at < 0) done_at = c;
      else if (fft_done && done2_at < 0 && c > done_at + 1) done2_at = c;
      if (c == DONE_CYC + 1) busy_gap = busy;
      tick();
    end
    start_fft = 1'b0;
    check("held_start_done1", done_at, DONE_CYC);
    check("held_start_idle_gap", busy_gap, 0);
    check("held_start_done2", done2_at, 2 * DONE_CYC + 1);
    repeat (DONE_CYC + 3) tick();

`ifdef FFT_AGU_BITREV_EN
    begin
      int ur[$];
      int exp_ur[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
      start_fft = 1'b1; tick(); start_fft = 1'b0;
      repeat (DONE_CYC + 3) begin
        if (unload_valid) ur.push_back(memb_address);
        tick();
      end
      check("unload_count", ur.size(), N);
      for (int i = 0; i < ur.size() && i < N; i++)
        check($sformatf("unload_memb[%0d]", i), ur[i], exp_ur[i]);
    end
`endif

    // Randomized start/hold/clr traffic
    for (int c = 0; c < 4000; c++) begin
      start_fft = ($urandom_range(0, 7) == 0);
      hold      = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 299) == 0) pulse_clr();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
